// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: the fetch PC XOR the speculative global history
// selects a 2-bit saturating counter whose MSB is the taken/not-taken
// prediction. Branch resolution in EX trains the counter and, on a
// mispredict, rewrites the history to the architecturally correct value.
module gshare_branch_predictor #(
  parameter int GHR_W  = 8,
  parameter int PC_LSB = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_en,
  input  logic             btb_hit,
  output logic             Gpre,
  output logic [GHR_W-1:0] pred_index,
  output logic [GHR_W-1:0] pred_ghr,
  output logic [GHR_W-1:0] GHR,
  input  logic             update_en,
  input  logic [GHR_W-1:0] update_index,
  input  logic             update_taken,
  input  logic             update_mispredict,
  input  logic [GHR_W-1:0] update_ghr
);

  localparam int ENTRIES = 1 << GHR_W;

  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  logic [GHR_W-1:0] idx;
  logic [1:0]       pht_q [ENTRIES];
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_d;

  // Prediction path is purely combinational, so the counter read sees the
  // value from before any same-edge training write.
  assign idx        = fetch_pc[PC_LSB+GHR_W-1:PC_LSB] ^ ghr_q;
  assign Gpre       = pht_q[idx][1];
  assign pred_index = idx;
  assign pred_ghr   = ghr_q;
  assign GHR        = ghr_q;

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    cnt_cur = pht_q[update_index];
    cnt_d   = cnt_cur;
    if (update_taken) begin
      if (cnt_cur != 2'd3) cnt_d = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'd0) cnt_d = cnt_cur - 2'd1;
    end
  end

  // History next state: repair beats the speculative shift; stalls and
  // non-branch fetches hold.
  always_comb begin
    ghr_d = ghr_q;
    if (update_en && update_mispredict) begin
      ghr_d = {update_ghr[GHR_W-2:0], update_taken};
    end else if (fetch_en && btb_hit) begin
      ghr_d = {ghr_q[GHR_W-2:0], Gpre};
    end
  end

  // History register; reset clears all speculation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Counter table; every entry resets to weakly not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (update_en) begin
      pht_q[update_index] <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor. The driver applies one vector
// per cycle just after the rising edge and queues the outputs it expects; a
// monitor pops the queue on the falling edge and compares.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_en = 1'b0;
  logic        btb_hit = 1'b0;
  logic        Gpre;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic [7:0]  GHR;
  logic        update_en = 1'b0;
  logic [7:0]  update_index = '0;
  logic        update_taken = 1'b0;
  logic        update_mispredict = 1'b0;
  logic [7:0]  update_ghr = '0;

  typedef struct {
    string      name;
    logic       gpre;
    logic [7:0] idx;
    logic [7:0] ghr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  gshare_branch_predictor #(.GHR_W(8), .PC_LSB(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_pc          (fetch_pc),
    .fetch_en          (fetch_en),
    .btb_hit           (btb_hit),
    .Gpre              (Gpre),
    .pred_index        (pred_index),
    .pred_ghr          (pred_ghr),
    .GHR               (GHR),
    .update_en         (update_en),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .update_ghr        (update_ghr)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue the expected outputs.
  task automatic cyc(input string nm, input logic rst_n, input logic [31:0] pc,
                     input logic en, input logic hit, input logic uen,
                     input logic [7:0] uidx, input logic utk, input logic umis,
                     input logic [7:0] ughr, input logic eg, input logic [7:0] ei,
                     input logic [7:0] eh);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst_n;
    fetch_pc          = pc;
    fetch_en          = en;
    btb_hit           = hit;
    update_en         = uen;
    update_index      = uidx;
    update_taken      = utk;
    update_mispredict = umis;
    update_ghr        = ughr;
    e.name = nm;
    e.gpre = eg;
    e.idx  = ei;
    e.ghr  = eh;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks += 3;
      if (Gpre !== e.gpre) begin
        n_fail++;
        $display("FAIL %s Gpre: got %b expected %b", e.name, Gpre, e.gpre);
      end
      if (pred_index !== e.idx) begin
        n_fail++;
        $display("FAIL %s pred_index: got %02h expected %02h", e.name, pred_index, e.idx);
      end
      if (GHR !== e.ghr || pred_ghr !== e.ghr) begin
        n_fail++;
        $display("FAIL %s GHR: got %02h/%02h expected %02h", e.name, GHR, pred_ghr, e.ghr);
      end
      $display("txn %-10s pc=%08h Gpre=%b idx=%02h ghr=%02h", e.name, fetch_pc, Gpre, pred_index, GHR);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name         rst pc         en hit uen uidx  tk mis ughr   Gpre idx    ghr
    cyc("rst_state",  0, 32'h40,     1, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("rst_hold",   0, 32'h40,     1, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("first_fet",  1, 32'h40,     1, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("train1",     1, 32'h40,     0, 0,  1, 8'h10, 1, 1, 8'h00, 0, 8'h10, 8'h00);
    cyc("train2",     1, 32'h40,     0, 0,  1, 8'h10, 1, 1, 8'h00, 0, 8'h11, 8'h01);
    cyc("repair0",    1, 32'h40,     0, 0,  1, 8'h30, 0, 1, 8'h00, 0, 8'h11, 8'h01);
    cyc("rbw",        1, 32'h40,     0, 0,  1, 8'h10, 0, 0, 8'h00, 1, 8'h10, 8'h00);
    // four increments starting from 2'b10
    cyc("inc1",       1, 32'h40,     0, 0,  1, 8'h10, 1, 0, 8'h00, 1, 8'h10, 8'h00);
    cyc("inc2",       1, 32'h40,     0, 0,  1, 8'h10, 1, 0, 8'h00, 1, 8'h10, 8'h00);
    cyc("inc3_sat",   1, 32'h40,     0, 0,  1, 8'h10, 1, 0, 8'h00, 1, 8'h10, 8'h00);
    cyc("inc4_sat",   1, 32'h40,     0, 0,  1, 8'h10, 1, 0, 8'h00, 1, 8'h10, 8'h00);
    // five decrements from 2'b11
    cyc("dec1",       1, 32'h40,     0, 0,  1, 8'h10, 0, 0, 8'h00, 1, 8'h10, 8'h00);
    cyc("dec2",       1, 32'h40,     0, 0,  1, 8'h10, 0, 0, 8'h00, 1, 8'h10, 8'h00);
    cyc("dec3",       1, 32'h40,     0, 0,  1, 8'h10, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("dec4_sat",   1, 32'h40,     0, 0,  1, 8'h10, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("dec5_sat",   1, 32'h40,     0, 0,  1, 8'h10, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    // two increments from 2'b00 reach 2'b10 only if zero held
    cyc("inc_a",      1, 32'h40,     0, 0,  1, 8'h10, 1, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("inc_b",      1, 32'h40,     0, 0,  1, 8'h10, 1, 0, 8'h00, 0, 8'h10, 8'h00);
    // speculative shifts, PC chosen so the index stays at 0x10
    cyc("spec1",      1, 32'h40,     1, 1,  0, 8'h00, 0, 0, 8'h00, 1, 8'h10, 8'h00);
    cyc("spec2",      1, 32'h44,     1, 1,  0, 8'h00, 0, 0, 8'h00, 1, 8'h10, 8'h01);
    cyc("spec3",      1, 32'h4C,     1, 1,  0, 8'h00, 0, 0, 8'h00, 1, 8'h10, 8'h03);
    for (int i = 0; i < 5; i++) begin
      cyc("stall",    1, 32'h40,     0, 1,  0, 8'h00, 0, 0, 8'h00, 0, 8'h17, 8'h07);
    end
    cyc("nonbranch",  1, 32'h40,     1, 0,  0, 8'h00, 0, 0, 8'h00, 0, 8'h17, 8'h07);
    cyc("to_a5",      1, 32'h40,     0, 0,  1, 8'h40, 1, 1, 8'h52, 0, 8'h17, 8'h07);
    cyc("mis_prio",   1, 32'h2D4,    1, 1,  1, 8'h50, 0, 1, 8'h3C, 1, 8'h10, 8'hA5);
    cyc("good_shift", 1, 32'h1A0,    1, 1,  1, 8'h60, 1, 0, 8'h00, 1, 8'h10, 8'h78);
    cyc("mis_no_en",  1, 32'h40,     0, 0,  0, 8'h00, 0, 1, 8'h00, 0, 8'hE1, 8'hF1);
    cyc("mis_no_en2", 1, 32'h40,     0, 0,  0, 8'h00, 0, 0, 8'h00, 0, 8'hE1, 8'hF1);
    // reset asserted between edges; sampled before any rising edge
    cyc("async_rst",  0, 32'h40,     0, 0,  0, 8'h00, 0, 0, 8'h00, 0, 8'h10, 8'h00);
    cyc("post_40",    1, 32'h100,    0, 0,  0, 8'h00, 0, 0, 8'h00, 0, 8'h40, 8'h00);
    cyc("post_60",    1, 32'h180,    0, 0,  0, 8'h00, 0, 0, 8'h00, 0, 8'h60, 8'h00);
    cyc("post_10",    1, 32'h40,     0, 0,  0, 8'h00, 0, 0, 8'h00, 0, 8'h10, 8'h00);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
